// File: rtl/fwd_source_pipe_if.sv
// Forwarding-source bundle: execute-stage capture, late load return, decode reads,
// the three priority triples, retire port and error flag.
interface fwd_source_pipe_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             Stall;
  logic             Flush;
  logic             In_Valid;
  logic [REGW-1:0]  In_Reg;
  logic [WIDTH-1:0] In_Data;
  logic             In_Ready;
  logic             Late_Valid;
  logic [WIDTH-1:0] Late_Data;
  logic [REGW-1:0]  Read_Reg1;
  logic [REGW-1:0]  Read_Reg2;

  logic [REGW-1:0]  WriteRegister1stPri1;
  logic [WIDTH-1:0] WriteData1stPri1;
  logic             Valid1stPri1;
  logic [REGW-1:0]  WriteRegister2ndPri1;
  logic [WIDTH-1:0] WriteData2ndPri1;
  logic             Valid2ndPri1;
  logic [REGW-1:0]  WriteRegister3rdPri1;
  logic [WIDTH-1:0] WriteData3rdPri1;
  logic             Valid3rdPri1;
  logic             Hazard_Stall;
  logic             RF_WE;
  logic [REGW-1:0]  RF_WReg;
  logic [WIDTH-1:0] RF_WData;
  logic             Err;

  modport master (
    output Stall, Flush, In_Valid, In_Reg, In_Data, In_Ready,
           Late_Valid, Late_Data, Read_Reg1, Read_Reg2,
    input  WriteRegister1stPri1, WriteData1stPri1, Valid1stPri1,
           WriteRegister2ndPri1, WriteData2ndPri1, Valid2ndPri1,
           WriteRegister3rdPri1, WriteData3rdPri1, Valid3rdPri1,
           Hazard_Stall, RF_WE, RF_WReg, RF_WData, Err
  );

  modport slave (
    input  Stall, Flush, In_Valid, In_Reg, In_Data, In_Ready,
           Late_Valid, Late_Data, Read_Reg1, Read_Reg2,
    output WriteRegister1stPri1, WriteData1stPri1, Valid1stPri1,
           WriteRegister2ndPri1, WriteData2ndPri1, Valid2ndPri1,
           WriteRegister3rdPri1, WriteData3rdPri1, Valid3rdPri1,
           Hazard_Stall, RF_WE, RF_WReg, RF_WData, Err
  );
endinterface

// File: rtl/fwd_source_pipe.sv
// Producer side of operand forwarding: three-stage result pipe (MEM, WB-pending, retire)
// with late load fill, load-use hazard detection and RF retire. Option: ZERO_REG_SUPPRESS_EN.
module fwd_source_pipe #(
  parameter       NAME  = "FWD",
  parameter int   WIDTH = 32,
  parameter int   REGW  = 5
) (
  input logic              CLK,
  input logic              RESET,
  fwd_source_pipe_if.slave bus
);

  if (NAME == "") begin : g_unnamed
  end

  logic             r_s1_v, r_s1_rdy, r_s2_v, r_s2_rdy, r_s3_v, r_s3_rdy;
  logic [REGW-1:0]  r_s1_reg, r_s2_reg, r_s3_reg;
  logic [WIDTH-1:0] r_s1_data, r_s2_data, r_s3_data;
  logic             r_err;

  logic             w_in_v;
  logic             w_late_hit;
  logic             w_hazard;
  logic [REGW-1:0]  w_rd;

`ifdef ZERO_REG_SUPPRESS_EN
  assign w_in_v = bus.In_Valid & ~bus.Flush & (|bus.In_Reg);
`else
  assign w_in_v = bus.In_Valid & ~bus.Flush;
`endif

  assign w_late_hit = bus.Late_Valid & r_s1_v & ~r_s1_rdy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_v <= 1'b0; r_s1_rdy <= 1'b0; r_s1_reg <= '0; r_s1_data <= '0;
      r_s2_v <= 1'b0; r_s2_rdy <= 1'b0; r_s2_reg <= '0; r_s2_data <= '0;
      r_s3_v <= 1'b0; r_s3_rdy <= 1'b0; r_s3_reg <= '0; r_s3_data <= '0;
      r_err  <= 1'b0;
    end else if (bus.Stall) begin
      // Frozen pipe: returning load data lands in s1 without moving it.
      if (w_late_hit) begin
        r_s1_rdy  <= 1'b1;
        r_s1_data <= bus.Late_Data;
      end
    end else begin
      r_s3_v    <= r_s2_v;
      r_s3_rdy  <= r_s2_rdy;
      r_s3_reg  <= r_s2_reg;
      r_s3_data <= r_s2_data;
      if (r_s2_v && !r_s2_rdy) r_err <= 1'b1;

      r_s2_v    <= r_s1_v;
      r_s2_reg  <= r_s1_reg;
      r_s2_rdy  <= r_s1_rdy | w_late_hit;
      r_s2_data <= w_late_hit ? bus.Late_Data : r_s1_data;

      r_s1_v    <= w_in_v;
      r_s1_rdy  <= bus.In_Ready;
      r_s1_reg  <= bus.In_Reg;
      r_s1_data <= bus.In_Data;
    end
  end

  // Only the highest-priority match decides; a ready younger copy masks an older load.
  always_comb begin
    w_hazard = 1'b0;
    w_rd     = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      w_rd = (k == 0) ? bus.Read_Reg1 : bus.Read_Reg2;
      if (w_rd != '0) begin
        if (r_s1_v && r_s1_reg == w_rd)      w_hazard = w_hazard | ~r_s1_rdy;
        else if (r_s2_v && r_s2_reg == w_rd) w_hazard = w_hazard | ~r_s2_rdy;
        else if (r_s3_v && r_s3_reg == w_rd) w_hazard = w_hazard | ~r_s3_rdy;
      end
    end
  end

  assign bus.WriteRegister1stPri1 = r_s1_reg;
  assign bus.WriteData1stPri1     = r_s1_data;
  assign bus.Valid1stPri1         = r_s1_v & r_s1_rdy;
  assign bus.WriteRegister2ndPri1 = r_s2_reg;
  assign bus.WriteData2ndPri1     = r_s2_data;
  assign bus.Valid2ndPri1         = r_s2_v & r_s2_rdy;
  assign bus.WriteRegister3rdPri1 = r_s3_reg;
  assign bus.WriteData3rdPri1     = r_s3_data;
  assign bus.Valid3rdPri1         = r_s3_v & r_s3_rdy;

  assign bus.Hazard_Stall = w_hazard;
  assign bus.RF_WE        = r_s3_v & r_s3_rdy & ~bus.Stall;
  assign bus.RF_WReg      = r_s3_reg;
  assign bus.RF_WData     = r_s3_data;
  assign bus.Err          = r_err;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Self-checking bench for fwd_source_pipe: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based pipe model.
module tb_fwd_source_pipe;

`ifdef ZERO_REG_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  fwd_source_pipe_if #(.WIDTH(32), .REGW(5)) bus ();

  fwd_source_pipe #(.NAME("FWD"), .WIDTH(32), .REGW(5)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    bit          v;
    bit          rdy;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t m[3];   // m[0]=s1 (MEM), m[1]=s2, m[2]=s3 (retire)
  bit   m_err;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m[i] = '{v: 1'b0, rdy: 1'b0, r: '0, d: '0};
    m_err = 1'b0;
  endtask

  task automatic model_step();
    ent_t e;
    if (RESET) begin
      model_clear();
    end else if (bus.Stall) begin
      if (bus.Late_Valid && m[0].v && !m[0].rdy) begin
        m[0].d   = bus.Late_Data;
        m[0].rdy = 1'b1;
      end
    end else begin
      e = m[0];
      if (bus.Late_Valid && e.v && !e.rdy) begin
        e.d   = bus.Late_Data;
        e.rdy = 1'b1;
      end
      if (m[1].v && !m[1].rdy) m_err = 1'b1;
      m[2] = m[1];
      m[1] = e;
      m[0].v   = bus.In_Valid && !bus.Flush && !(ZS && bus.In_Reg == 5'd0);
      m[0].rdy = bus.In_Ready;
      m[0].r   = bus.In_Reg;
      m[0].d   = bus.In_Data;
    end
  endtask

  function automatic bit model_hazard(input logic [4:0] rr);
    if (rr == 5'd0) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (m[i].v && m[i].r == rr) return !m[i].rdy;
    return 1'b0;
  endfunction

  task automatic cmp_model();
    chk("s1.reg",  bus.WriteRegister1stPri1, m[0].r);
    chk("s1.data", bus.WriteData1stPri1,     m[0].d);
    chk("s1.valid",bus.Valid1stPri1,         m[0].v && m[0].rdy);
    chk("s2.reg",  bus.WriteRegister2ndPri1, m[1].r);
    chk("s2.data", bus.WriteData2ndPri1,     m[1].d);
    chk("s2.valid",bus.Valid2ndPri1,         m[1].v && m[1].rdy);
    chk("s3.reg",  bus.WriteRegister3rdPri1, m[2].r);
    chk("s3.data", bus.WriteData3rdPri1,     m[2].d);
    chk("s3.valid",bus.Valid3rdPri1,         m[2].v && m[2].rdy);
    chk("hazard",  bus.Hazard_Stall, model_hazard(bus.Read_Reg1) || model_hazard(bus.Read_Reg2));
    chk("rf_we",   bus.RF_WE,    m[2].v && m[2].rdy && !bus.Stall);
    chk("rf_wreg", bus.RF_WReg,  m[2].r);
    chk("rf_wdata",bus.RF_WData, m[2].d);
    chk("err",     bus.Err,      m_err);
  endtask

  task automatic drv(input bit v = 0, input logic [4:0] r = 0, input logic [31:0] d = 0,
                     input bit rdy = 0, input bit st = 0, input bit fl = 0,
                     input bit lv = 0, input logic [31:0] ld = 0,
                     input logic [4:0] rr1 = 0, input logic [4:0] rr2 = 0);
    bus.In_Valid = v;   bus.In_Reg = r;      bus.In_Data = d;   bus.In_Ready = rdy;
    bus.Stall = st;     bus.Flush = fl;      bus.Late_Valid = lv; bus.Late_Data = ld;
    bus.Read_Reg1 = rr1; bus.Read_Reg2 = rr2;
    #1;
    cmp_model();
  endtask

  task automatic adv();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic reset_pulse();
    RESET = 1'b1;
    #1;
    model_clear();
    chk("rst.v1",  bus.Valid1stPri1, 1'b0);
    chk("rst.v2",  bus.Valid2ndPri1, 1'b0);
    chk("rst.v3",  bus.Valid3rdPri1, 1'b0);
    chk("rst.we",  bus.RF_WE, 1'b0);
    chk("rst.err", bus.Err, 1'b0);
    cmp_model();
    #1 RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    model_clear();
    drv();
    chk("init.v1",  bus.Valid1stPri1, 1'b0);
    chk("init.we",  bus.RF_WE, 1'b0);
    chk("init.err", bus.Err, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

    // Single ready result walks s1 -> s2 -> s3 and retires.
    drv(.v(1), .r(5), .d(32'hDEADBEEF), .rdy(1)); adv();
    drv(); chk("p1.v1", bus.Valid1stPri1, 1'b1); chk("p1.reg1", bus.WriteRegister1stPri1, 5'd5); adv();
    drv(); chk("p2.v2", bus.Valid2ndPri1, 1'b1); chk("p2.v1", bus.Valid1stPri1, 1'b0); adv();
    drv(); chk("p3.v3", bus.Valid3rdPri1, 1'b1); chk("p3.we", bus.RF_WE, 1'b1);
    chk("p3.wreg", bus.RF_WReg, 5'd5); chk("p3.wdata", bus.RF_WData, 32'hDEADBEEF); adv();
    drv(); chk("p4.we", bus.RF_WE, 1'b0); adv();

    // Load-use: hazard while in s1, late fill on the shift edge.
    drv(.v(1), .r(8), .d(32'h0), .rdy(0), .rr1(8)); chk("ld.hz0", bus.Hazard_Stall, 1'b0); adv();
    drv(.lv(1), .ld(32'h1234), .rr1(8)); chk("ld.hz1", bus.Hazard_Stall, 1'b1); adv();
    drv(.rr1(8)); chk("ld.v2", bus.Valid2ndPri1, 1'b1);
    chk("ld.d2", bus.WriteData2ndPri1, 32'h1234); chk("ld.hz2", bus.Hazard_Stall, 1'b0); adv();
    drv(); adv();
    drv(); adv();

    // Stall with all stages full; late fill updates s1 in place.
    drv(.v(1), .r(1), .d(32'h11), .rdy(1)); adv();
    drv(.v(1), .r(2), .d(32'h22), .rdy(1)); adv();
    drv(.v(1), .r(3), .d(32'h33), .rdy(0)); adv();
    drv(.v(1), .r(7), .d(32'h77), .rdy(1), .st(1), .fl(1));
    chk("st1.we", bus.RF_WE, 1'b0); chk("st1.v3", bus.Valid3rdPri1, 1'b1);
    chk("st1.r3", bus.WriteRegister3rdPri1, 5'd1); adv();
    drv(.st(1), .lv(1), .ld(32'h55)); chk("st2.we", bus.RF_WE, 1'b0); adv();
    drv(.st(1)); chk("st3.v1", bus.Valid1stPri1, 1'b1); chk("st3.d1", bus.WriteData1stPri1, 32'h55);
    chk("st3.we", bus.RF_WE, 1'b0); chk("st3.r2", bus.WriteRegister2ndPri1, 5'd2); adv();
    drv(); chk("st4.we", bus.RF_WE, 1'b1); chk("st4.wreg", bus.RF_WReg, 5'd1); adv();

    // Flush drops only the incoming entry.
    drv(.v(1), .r(3), .d(32'h99), .rdy(1), .fl(1)); adv();
    drv(); chk("fl.v1", bus.Valid1stPri1, 1'b0); chk("fl.v2", bus.Valid2ndPri1, 1'b0);
    chk("fl.v3", bus.Valid3rdPri1, 1'b1); chk("fl.d3", bus.WriteData3rdPri1, 32'h55); adv();

    // Unfilled load reaches s3: sticky error, no write.
    drv(.v(1), .r(9), .d(32'hABCD), .rdy(0)); adv();
    drv(); chk("er.e0", bus.Err, 1'b0); adv();
    drv(); chk("er.e1", bus.Err, 1'b0); adv();
    drv(); chk("er.e2", bus.Err, 1'b1); chk("er.we", bus.RF_WE, 1'b0); adv();

    // Async reset with full pipe.
    drv(.v(1), .r(4), .d(32'h4), .rdy(1)); adv();
    drv(.v(1), .r(6), .d(32'h6), .rdy(1)); adv();
    drv(.v(1), .r(10), .d(32'hA), .rdy(1)); adv();
    drv();
    reset_pulse();
    adv();

    // Register-0 entry: suppressed only when the option is built in.
    drv(.v(1), .r(0), .d(32'h0F0F), .rdy(1)); adv();
    drv(); chk("z.v1", bus.Valid1stPri1, !ZS); adv();
    drv(); chk("z.v2", bus.Valid2ndPri1, !ZS); adv();
    drv(); chk("z.v3", bus.Valid3rdPri1, !ZS); chk("z.we", bus.RF_WE, !ZS); adv();

    for (int n = 0; n < 3000; n++) begin
      drv(.v($urandom_range(0, 3) != 0), .r(5'($urandom_range(0, 7))), .d($urandom),
          .rdy($urandom_range(0, 9) < 7), .st($urandom_range(0, 4) == 0),
          .fl($urandom_range(0, 9) == 0), .lv($urandom_range(0, 9) < 3), .ld($urandom),
          .rr1(5'($urandom_range(0, 7))), .rr2(5'($urandom_range(0, 7))));
      if ($urandom_range(0, 199) == 0) reset_pulse();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
